// File: rtl/pwm_reg_bank.sv
// SPI-driven register bank for a PWM block: period, prescaler, per-channel duty,
// enable and a sticky error flag, accessed by a byte-oriented read/write protocol.
module pwm_reg_bank #(
    parameter int NUM_CH      = 3,
    parameter int REG_BYTES   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst_L,
    // Handshake: o_RX_DV is a one-cycle strobe qualifying o_RX_Byte; there is no
    // back-pressure, every strobe is consumed. i_TX_DV is a one-cycle strobe that
    // loads i_TX_Byte into the SPI slave; i_TX_Byte holds between strobes.
    input  logic                            o_RX_DV,
    input  logic [7:0]                      o_RX_Byte,
    output logic                            i_TX_DV,
    output logic [7:0]                      i_TX_Byte,
    output logic [8*REG_BYTES-1:0]          counter_value,
    output logic [8*REG_BYTES-1:0]          prescaler,
    output logic [NUM_CH*8*REG_BYTES-1:0]   duty_cycle,
    output logic                            enable_pwm,
    output logic                            err_flag,
    output logic [1:0]                      dbg_state_o
);

    localparam int W   = 8 * REG_BYTES;
    localparam int CW  = ($clog2(REG_BYTES + 1) > 1) ? $clog2(REG_BYTES + 1) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [6:0] ADDR_STATUS  = 7'h00;
    localparam logic [6:0] ADDR_COUNTER = 7'h01;
    localparam logic [6:0] ADDR_PRESC   = 7'h02;
    localparam logic [6:0] ADDR_DISABLE = 7'h7E;
    localparam logic [6:0] ADDR_ENABLE  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       rd_len_q, rd_len_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [6:0]          addr_q, addr_d;
    logic [W-1:0]        shadow_q, shadow_d;
    logic [W-1:0]        rd_data_q, rd_data_d;
    logic [W-1:0]        counter_q, counter_d;
    logic [W-1:0]        presc_q, presc_d;
    logic [NUM_CH*W-1:0] duty_q, duty_d;
    logic                en_q, en_d;
    logic                err_q, err_d;
    logic                tx_dv_q, tx_dv_d;
    logic [7:0]          tx_byte_q, tx_byte_d;

    logic                cmd_rd;
    logic [6:0]          cmd_addr;
    logic                cmd_is_duty;
    logic                cmd_is_data;
    logic [W-1:0]        rd_val;
    logic [W-1:0]        wr_val;
    logic [7:0]          tx_next;
    logic                err_set;
    logic                err_clr;
    logic                tmo_hit;

    assign cmd_rd      = o_RX_Byte[7];
    assign cmd_addr    = o_RX_Byte[6:0];
    assign cmd_is_duty = (cmd_addr[6:4] == 3'b001) && (int'(cmd_addr[3:0]) < NUM_CH);
    assign cmd_is_data = (cmd_addr == ADDR_COUNTER) || (cmd_addr == ADDR_PRESC) || cmd_is_duty;
    assign tmo_hit     = (tmo_q == TW'(TIMEOUT_CYC - 1));

    // Value snapshotted when a read command is accepted.
    always_comb begin
        rd_val = '0;
        if (cmd_addr == ADDR_STATUS) begin
            rd_val = W'({6'b0, err_q, en_q});
        end else if (cmd_addr == ADDR_COUNTER) begin
            rd_val = counter_q;
        end else if (cmd_addr == ADDR_PRESC) begin
            rd_val = presc_q;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (cmd_addr[3:0] == 4'(k)) begin
                    rd_val = duty_q[k*W +: W];
                end
            end
        end
    end

    // Shadow with the incoming byte merged at the current byte position.
    always_comb begin
        wr_val = shadow_q;
        for (int b = 0; b < REG_BYTES; b++) begin
            if (cnt_q == CW'(b)) begin
                wr_val[b*8 +: 8] = o_RX_Byte;
            end
        end
    end

    always_comb begin
        tx_next = '0;
        for (int b = 0; b < REG_BYTES; b++) begin
            if (cnt_q == CW'(b)) begin
                tx_next = rd_data_q[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_len_d  = rd_len_q;
        tmo_d     = tmo_q;
        addr_d    = addr_q;
        shadow_d  = shadow_q;
        rd_data_d = rd_data_q;
        counter_d = counter_q;
        presc_d   = presc_q;
        duty_d    = duty_q;
        en_d      = en_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        err_set   = 1'b0;
        err_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (o_RX_DV) begin
                    if (!cmd_rd && cmd_addr == ADDR_ENABLE) begin
                        en_d = 1'b1;
                    end else if (!cmd_rd && cmd_addr == ADDR_DISABLE) begin
                        en_d = 1'b0;
                    end else if (!cmd_rd && cmd_is_data) begin
                        addr_d   = cmd_addr;
                        cnt_d    = '0;
                        shadow_d = '0;
                        state_d  = WR_DATA;
                    end else if (cmd_rd && (cmd_is_data || cmd_addr == ADDR_STATUS)) begin
                        addr_d    = cmd_addr;
                        rd_data_d = rd_val;
                        rd_len_d  = (cmd_addr == ADDR_STATUS) ? CW'(1) : CW'(REG_BYTES);
                        tx_byte_d = rd_val[7:0];
                        tx_dv_d   = 1'b1;
                        cnt_d     = CW'(1);
                        state_d   = RD_DATA;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end

            WR_DATA: begin
                if (o_RX_DV) begin
                    tmo_d = '0;
                    if (cnt_q == CW'(REG_BYTES - 1)) begin
                        // Full word lands in one edge so outputs never show a partial value.
                        if (addr_q == ADDR_COUNTER) begin
                            counter_d = wr_val;
                        end else if (addr_q == ADDR_PRESC) begin
                            presc_d = wr_val;
                        end else begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                if (addr_q[3:0] == 4'(k)) begin
                                    duty_d[k*W +: W] = wr_val;
                                end
                            end
                        end
                        state_d = IDLE;
                    end else begin
                        shadow_d = wr_val;
                        cnt_d    = cnt_q + CW'(1);
                    end
                end else if (tmo_hit) begin
                    shadow_d = '0;
                    tmo_d    = '0;
                    err_set  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            RD_DATA: begin
                // A status byte just handed to the slave clears the sticky error.
                if (tx_dv_q && addr_q == ADDR_STATUS) begin
                    err_clr = 1'b1;
                end
                if (o_RX_DV) begin
                    tmo_d = '0;
                    if (cnt_q == rd_len_q) begin
                        state_d = IDLE;
                    end else begin
                        tx_byte_d = tx_next;
                        tx_dv_d   = 1'b1;
                        cnt_d     = cnt_q + CW'(1);
                    end
                end else if (tmo_hit) begin
                    tmo_d   = '0;
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_len_q  <= '0;
            tmo_q     <= '0;
            addr_q    <= '0;
            shadow_q  <= '0;
            rd_data_q <= '0;
            counter_q <= '0;
            presc_q   <= '0;
            duty_q    <= '0;
            en_q      <= 1'b0;
            err_q     <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_len_q  <= rd_len_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            shadow_q  <= shadow_d;
            rd_data_q <= rd_data_d;
            counter_q <= counter_d;
            presc_q   <= presc_d;
            duty_q    <= duty_d;
            en_q      <= en_d;
            err_q     <= err_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    assign i_TX_DV       = tx_dv_q;
    assign i_TX_Byte     = tx_byte_q;
    assign counter_value = counter_q;
    assign prescaler     = presc_q;
    assign duty_cycle    = duty_q;
    assign enable_pwm    = en_q;
    assign err_flag      = err_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_pwm_reg_bank.sv
// Directed bench for pwm_reg_bank: a byte-stream vector table on the default
// configuration, hand sequences for timeout/reset, and a single-byte instance.
module tb_pwm_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // Default configuration: NUM_CH=3, REG_BYTES=4, TIMEOUT_CYC=16
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic [31:0] counter_value;
    logic [31:0] prescaler;
    logic [95:0] duty;
    logic        en;
    logic        err;
    logic [1:0]  st;

    // Narrow configuration: NUM_CH=1, REG_BYTES=1
    logic        rx1_dv;
    logic [7:0]  rx1_byte;
    logic        tx1_dv;
    logic [7:0]  tx1_byte;
    logic [7:0]  cnt1;
    logic [7:0]  pre1;
    logic [7:0]  duty1;
    logic        en1;
    logic        err1;
    logic [1:0]  st1;

    pwm_reg_bank #(.NUM_CH(3), .REG_BYTES(4), .TIMEOUT_CYC(16)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .o_RX_DV(rx_dv), .o_RX_Byte(rx_byte),
        .i_TX_DV(tx_dv), .i_TX_Byte(tx_byte), .counter_value(counter_value),
        .prescaler(prescaler), .duty_cycle(duty), .enable_pwm(en),
        .err_flag(err), .dbg_state_o(st)
    );

    pwm_reg_bank #(.NUM_CH(1), .REG_BYTES(1), .TIMEOUT_CYC(16)) dut1 (
        .i_Clk(clk), .i_Rst_L(rst_n), .o_RX_DV(rx1_dv), .o_RX_Byte(rx1_byte),
        .i_TX_DV(tx1_dv), .i_TX_Byte(tx1_byte), .counter_value(cnt1),
        .prescaler(pre1), .duty_cycle(duty1), .enable_pwm(en1),
        .err_flag(err1), .dbg_state_o(st1)
    );

    typedef struct packed {
        logic [7:0]  rx;
        logic [31:0] cnt;
        logic [31:0] duty2;
        logic        en;
        logic        err;
        logic [1:0]  st;
        logic        txdv;
        logic [7:0]  txb;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    always @(negedge clk) begin
        if (rst_n && tx_dv) got_q.push_back(tx_byte);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] rx, input logic [31:0] c, input logic [31:0] d2,
                       input logic e, input logic er, input logic [1:0] s,
                       input logic tv, input logic [7:0] tb);
        vec_t v;
        v = '{rx: rx, cnt: c, duty2: d2, en: e, err: er, st: s, txdv: tv, txb: tb};
        vq.push_back(v);
    endtask

    // Called #1 after a clock edge; returns #1 after the edge that sampled the byte.
    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        rx1_dv   = 1'b1;
        rx1_byte = b;
        @(posedge clk);
        #1;
        rx1_dv   = 1'b0;
    endtask

    task automatic flush_scoreboard(input string tag);
        check({tag, " tx count"}, 128'(got_q.size()), 128'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, " tx byte"}, 128'(g), 128'(e));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_dv    = 1'b0;
        rx_byte  = 8'h00;
        rx1_dv   = 1'b0;
        rx1_byte = 8'h00;

        //   rx     counter       duty[95:64]   en    err   st     txdv  txb
        add(8'h01, 32'h0,        32'h0,        1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
        add(8'h78, 32'h0,        32'h0,        1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
        add(8'h56, 32'h0,        32'h0,        1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
        add(8'h34, 32'h0,        32'h0,        1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
        add(8'h12, 32'h12345678, 32'h0,        1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        add(8'h12, 32'h12345678, 32'h0,        1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
        add(8'hAA, 32'h12345678, 32'h0,        1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
        add(8'hBB, 32'h12345678, 32'h0,        1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
        add(8'hCC, 32'h12345678, 32'h0,        1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
        add(8'hDD, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        add(8'h7F, 32'h12345678, 32'hDDCCBBAA, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00);
        add(8'h92, 32'h12345678, 32'hDDCCBBAA, 1'b1, 1'b0, 2'd2, 1'b1, 8'hAA);
        add(8'h00, 32'h12345678, 32'hDDCCBBAA, 1'b1, 1'b0, 2'd2, 1'b1, 8'hBB);
        add(8'h00, 32'h12345678, 32'hDDCCBBAA, 1'b1, 1'b0, 2'd2, 1'b1, 8'hCC);
        add(8'h00, 32'h12345678, 32'hDDCCBBAA, 1'b1, 1'b0, 2'd2, 1'b1, 8'hDD);
        add(8'h00, 32'h12345678, 32'hDDCCBBAA, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00);
        add(8'h7E, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        add(8'h13, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
        add(8'h80, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b1, 2'd2, 1'b1, 8'h02);
        add(8'hFF, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        add(8'hFE, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
        add(8'h81, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b1, 2'd2, 1'b1, 8'h78);
        add(8'h00, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b1, 2'd2, 1'b1, 8'h56);
        add(8'h00, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b1, 2'd2, 1'b1, 8'h34);
        add(8'h00, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b1, 2'd2, 1'b1, 8'h12);
        add(8'h00, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
        add(8'h80, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b1, 2'd2, 1'b1, 8'h02);
        add(8'h00, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        add(8'h05, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
        add(8'h80, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b1, 2'd2, 1'b1, 8'h02);
        add(8'h00, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        add(8'h00, 32'h12345678, 32'hDDCCBBAA, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
        add(8'h7F, 32'h12345678, 32'hDDCCBBAA, 1'b1, 1'b1, 2'd0, 1'b0, 8'h00);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset counter", 128'(counter_value), 128'h0);
        check("reset prescaler", 128'(prescaler), 128'h0);
        check("reset duty", 128'(duty), 128'h0);
        check("reset en", 128'(en), 128'h0);
        check("reset err", 128'(err), 128'h0);
        check("reset tx_dv", 128'(tx_dv), 128'h0);
        check("reset tx_byte", 128'(tx_byte), 128'h0);
        check("reset state", 128'(st), 128'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            send_byte(vq[i].rx);
            check($sformatf("row%0d counter", i), 128'(counter_value), 128'(vq[i].cnt));
            check($sformatf("row%0d duty2", i), 128'(duty[95:64]), 128'(vq[i].duty2));
            check($sformatf("row%0d en", i), 128'(en), 128'(vq[i].en));
            check($sformatf("row%0d err", i), 128'(err), 128'(vq[i].err));
            check($sformatf("row%0d state", i), 128'(st), 128'(vq[i].st));
            check($sformatf("row%0d tx_dv", i), 128'(tx_dv), 128'(vq[i].txdv));
            if (vq[i].txdv) exp_q.push_back(vq[i].txb);
        end
        check("tx_byte hold", 128'(tx_byte), 128'h02);

        // Clear the sticky error via status read (en=1, err=1)
        send_byte(8'h80);
        exp_q.push_back(8'h03);
        send_byte(8'h00);
        check("status clr err", 128'(err), 128'h0);

        // Timeout mid-write: prescaler untouched, error raised after 16 idle clocks
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (15) @(posedge clk);
        #1;
        check("tmo pre state", 128'(st), 128'd1);
        check("tmo pre err", 128'(err), 128'h0);
        @(posedge clk);
        #1;
        check("tmo err", 128'(err), 128'h1);
        check("tmo state", 128'(st), 128'd0);
        check("tmo prescaler", 128'(prescaler), 128'h0);
        send_byte(8'h02);
        check("post tmo cmd", 128'(st), 128'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("presc partial", 128'(prescaler), 128'h0);
        send_byte(8'h04);
        check("presc commit", 128'(prescaler), 128'h04030201);
        send_byte(8'h82);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        repeat (4) send_byte(8'h00);
        check("presc read done", 128'(st), 128'd0);
        flush_scoreboard("main");

        // Reset in the middle of a duty write
        send_byte(8'h10);
        send_byte(8'hAB);
        send_byte(8'hCD);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst counter", 128'(counter_value), 128'h0);
        check("arst prescaler", 128'(prescaler), 128'h0);
        check("arst duty", 128'(duty), 128'h0);
        check("arst en", 128'(en), 128'h0);
        check("arst err", 128'(err), 128'h0);
        check("arst tx_byte", 128'(tx_byte), 128'h0);
        check("arst state", 128'(st), 128'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_byte(8'h7F);
        check("post rst en", 128'(en), 128'h1);
        check("post rst state", 128'(st), 128'd0);
        check("post rst duty", 128'(duty), 128'h0);

        // Single-byte registers, single channel
        send1(8'h01);
        check("n1 wr state", 128'(st1), 128'd1);
        send1(8'h78);
        check("n1 counter", 128'(cnt1), 128'h78);
        check("n1 idle", 128'(st1), 128'd0);
        send1(8'h80);
        check("n1 status dv", 128'(tx1_dv), 128'h1);
        check("n1 status byte", 128'(tx1_byte), 128'h00);
        send1(8'h00);
        check("n1 status end", 128'(st1), 128'd0);
        check("n1 status end dv", 128'(tx1_dv), 128'h0);
        send1(8'h11);
        check("n1 bad duty err", 128'(err1), 128'h1);
        send1(8'h81);
        check("n1 rd counter", 128'(tx1_byte), 128'h78);
        send1(8'h00);
        check("n1 rd end", 128'(st1), 128'd0);
        send1(8'h10);
        send1(8'h5A);
        check("n1 duty", 128'(duty1), 128'h5A);
        send1(8'h80);
        check("n1 status err byte", 128'(tx1_byte), 128'h02);
        send1(8'h00);
        check("n1 err cleared", 128'(err1), 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
